// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: rotating NUM_PHASES-approach signal controller
// with per-phase green times, a one-shot sensor green extension and an
// optional pedestrian walk interval (present only when TRAFFIC_WALK_EN is defined).
// Latency: async inputs take 2 clk to sync; edges act on the 3rd clk.
// State changes show on the clk edge after the expiring tick.
// Backpressure: none; lamps and status are always driven from registered state.
// Ports: clk/Reset (sync, active-high); Sensor, Walk_Request, Reprogram (async).
// Time_Parameter_Selector/Phase_Select/Time_Value form the programming word.
// Green/Yellow/Red/Walk are the lamp drives.
// Phase/Remaining report the served approach and the seconds left.
module traffic_phase_controller #(
  parameter int NUM_PHASES = 4,
  parameter int TIME_W     = 4,
  parameter int CLK_DIV    = 100000000,
  parameter int DEF_GREEN  = 6,
  parameter int DEF_YELLOW = 2,
  parameter int DEF_EXT    = 3,
  parameter int DEF_WALK   = 3
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [NUM_PHASES-1:0]         Sensor,
  input  logic                          Walk_Request,
  input  logic                          Reprogram,
  input  logic [1:0]                    Time_Parameter_Selector,
  input  logic [$clog2(NUM_PHASES)-1:0] Phase_Select,
  input  logic [TIME_W-1:0]             Time_Value,
  output logic [NUM_PHASES-1:0]         Green,
  output logic [NUM_PHASES-1:0]         Yellow,
  output logic [NUM_PHASES-1:0]         Red,
  output logic                          Walk,
  output logic [$clog2(NUM_PHASES)-1:0] Phase,
  output logic [TIME_W-1:0]             Remaining
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [PW-1:0]     LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam logic [DW-1:0]     DIV_MAX    = DW'(CLK_DIV - 1);
  localparam logic [TIME_W-1:0] ONE        = TIME_W'(1);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d, next_phase;
  logic [TIME_W-1:0]     rem_q, load_val, walk_time;
  logic [DW-1:0]         div_q;
  logic                  ext_used_q;
  logic [NUM_PHASES-1:0] sens_s1_q, sens_s2_q;
  logic [2:0]            rp_q;  // [0] first flop, [1] synced, [2] synced delayed
  logic                  rp_rise, walk_pend, enter, tick, expire, ext_take;

  logic [TIME_W-1:0]     green_q [NUM_PHASES];
  logic [TIME_W-1:0]     yellow_q, ext_q;

  // Zero on the programming bus means "restore the reset default".
  function automatic logic [TIME_W-1:0] pick(input logic [TIME_W-1:0] val,
                                             input logic [TIME_W-1:0] def);
    return (val == '0) ? def : val;
  endfunction

  // Input synchronisers
  always_ff @(posedge clk) begin
    if (Reset) begin
      sens_s1_q <= '0;
      sens_s2_q <= '0;
      rp_q      <= '0;
    end else begin
      sens_s1_q <= Sensor;
      sens_s2_q <= sens_s1_q;
      rp_q      <= {rp_q[1:0], Reprogram};
    end
  end

  assign rp_rise = rp_q[1] & ~rp_q[2];

`ifdef TRAFFIC_WALK_EN
  logic [2:0]        wr_q;
  logic              walk_rise, walk_latch_q;
  logic [TIME_W-1:0] walk_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_q <= '0;
    end else begin
      wr_q <= {wr_q[1:0], Walk_Request};
    end
  end

  assign walk_rise = wr_q[1] & ~wr_q[2];

  // A new press wins over the clear, so a request arriving as WALK starts
  // is kept for the following round instead of being swallowed.
  always_ff @(posedge clk) begin
    if (Reset) begin
      walk_latch_q <= 1'b0;
    end else if (walk_rise) begin
      walk_latch_q <= 1'b1;
    end else if (enter && state_d == S_WALK) begin
      walk_latch_q <= 1'b0;
    end
  end

  assign walk_pend = walk_latch_q;
  assign walk_time = walk_q;
`else
  logic walk_unused;
  assign walk_unused = Walk_Request;
  assign walk_pend   = 1'b0;
  assign walk_time   = ONE;
`endif

  // Timing register file; a write never disturbs a state already loaded.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PHASES; i++) green_q[i] <= TIME_W'(DEF_GREEN);
      yellow_q <= TIME_W'(DEF_YELLOW);
      ext_q    <= TIME_W'(DEF_EXT);
`ifdef TRAFFIC_WALK_EN
      walk_q   <= TIME_W'(DEF_WALK);
`endif
    end else if (rp_rise) begin
      case (Time_Parameter_Selector)
        2'b00: begin
          for (int i = 0; i < NUM_PHASES; i++) begin
            if (Phase_Select == PW'(i)) green_q[i] <= pick(Time_Value, TIME_W'(DEF_GREEN));
          end
        end
        2'b01: yellow_q <= pick(Time_Value, TIME_W'(DEF_YELLOW));
        2'b10: ext_q    <= pick(Time_Value, TIME_W'(DEF_EXT));
        2'b11: begin
`ifdef TRAFFIC_WALK_EN
          walk_q <= pick(Time_Value, TIME_W'(DEF_WALK));
`endif
        end
      endcase
    end
  end

  assign tick       = (div_q == DIV_MAX);
  assign expire     = tick && (rem_q == ONE);
  assign ext_take   = (state_q == S_GREEN) && expire && sens_s2_q[phase_q] && !ext_used_q;
  assign next_phase = (phase_q == LAST_PHASE) ? '0 : phase_q + PW'(1);
  assign enter      = (state_d != state_q);

  // FSM state register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_ALLRED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (expire) begin
      case (state_q)
        S_GREEN:  if (!ext_take) state_d = S_YELLOW;
        S_YELLOW: state_d = S_ALLRED;
        S_ALLRED: begin
          phase_d = next_phase;
          state_d = (walk_pend && next_phase == '0) ? S_WALK : S_GREEN;
        end
        default:  state_d = S_GREEN;
      endcase
    end
  end

  // Duration loaded on entry to the next state; reads the pre-write register.
  always_comb begin
    case (state_d)
      S_GREEN:  load_val = green_q[phase_d];
      S_YELLOW: load_val = yellow_q;
      S_ALLRED: load_val = ONE;
      default:  load_val = walk_time;
    endcase
  end

  // Phase, countdown and divider. Restarting the divider on every load makes
  // each state last exactly N whole ticks.
  always_ff @(posedge clk) begin
    if (Reset) begin
      phase_q    <= LAST_PHASE;
      rem_q      <= ONE;
      div_q      <= '0;
      ext_used_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (enter) begin
        rem_q <= load_val;
        div_q <= '0;
      end else if (ext_take) begin
        rem_q <= ext_q;
        div_q <= '0;
      end else if (tick) begin
        rem_q <= rem_q - ONE;
        div_q <= '0;
      end else begin
        div_q <= div_q + DW'(1);
      end
      if (enter && state_d == S_GREEN) begin
        ext_used_q <= 1'b0;
      end else if (ext_take) begin
        ext_used_q <= 1'b1;
      end
    end
  end

  // FSM outputs
  always_comb begin
    Green  = '0;
    Yellow = '0;
    Walk   = 1'b0;
    case (state_q)
      S_GREEN:  Green[phase_q]  = 1'b1;
      S_YELLOW: Yellow[phase_q] = 1'b1;
`ifdef TRAFFIC_WALK_EN
      S_WALK:   Walk = 1'b1;
`endif
      default:  ;
    endcase
    Red = ~(Green | Yellow);
  end

  assign Phase     = phase_q;
  assign Remaining = rem_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: directed rotation/extension/walk/program/reset
// scenarios plus randomized traffic, checked against a cycle-count model.
module tb_traffic_phase_controller;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int CD = 4;
`ifdef TRAFFIC_WALK_EN
  localparam int WALK_CYC = 12;
  localparam bit WEN      = 1'b1;
`else
  localparam int WALK_CYC = 0;
  localparam bit WEN      = 1'b0;
`endif
  localparam int M_G = 0, M_Y = 1, M_R = 2, M_W = 3;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic [N-1:0]  Sensor = '0;
  logic          Walk_Request = 1'b0;
  logic          Reprogram = 1'b0;
  logic [1:0]    Time_Parameter_Selector = 2'b00;
  logic [1:0]    Phase_Select = 2'b00;
  logic [TW-1:0] Time_Value = '0;
  logic [N-1:0]  Green, Yellow, Red;
  logic          Walk;
  logic [1:0]    Phase;
  logic [TW-1:0] Remaining;

  traffic_phase_controller #(.NUM_PHASES(N), .TIME_W(TW), .CLK_DIV(CD)) dut (
    .clk(clk), .Reset(Reset), .Sensor(Sensor), .Walk_Request(Walk_Request),
    .Reprogram(Reprogram), .Time_Parameter_Selector(Time_Parameter_Selector),
    .Phase_Select(Phase_Select), .Time_Value(Time_Value), .Green(Green),
    .Yellow(Yellow), .Red(Red), .Walk(Walk), .Phase(Phase), .Remaining(Remaining)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  // Reference model: each state is a number of clk cycles left; inputs are
  // seen through their 2-cycle synchroniser delay.
  int m_state, m_phase, m_left, m_yellow, m_extv, m_walkv;
  int m_green [N];
  bit m_ext, m_walk;
  logic [N-1:0] sh1, sh2;
  bit wh1, wh2, wh3, rh1, rh2, rh3;

  always @(posedge clk) begin : model
    logic [N-1:0] ss;
    bit w_rise, r_rise, pend;
    if (Reset) begin
      m_state = M_R; m_phase = N - 1; m_left = CD; m_ext = 0; m_walk = 0;
      for (int i = 0; i < N; i++) m_green[i] = 6;
      m_yellow = 2; m_extv = 3; m_walkv = 3;
      sh1 = '0; sh2 = '0; wh1 = 0; wh2 = 0; wh3 = 0; rh1 = 0; rh2 = 0; rh3 = 0;
    end else begin
      ss = sh2; w_rise = wh2 && !wh3; r_rise = rh2 && !rh3; pend = m_walk;
      if (m_left > 1) begin
        m_left--;
      end else begin
        case (m_state)
          M_G: if (ss[m_phase] && !m_ext) begin
                 m_left = m_extv * CD; m_ext = 1;
               end else begin
                 m_state = M_Y; m_left = m_yellow * CD;
               end
          M_Y: begin m_state = M_R; m_left = CD; end
          M_R: begin
            m_phase = (m_phase + 1) % N;
            if (WEN && pend && m_phase == 0) begin
              m_state = M_W; m_left = m_walkv * CD; m_walk = 0;
            end else begin
              m_state = M_G; m_left = m_green[m_phase] * CD; m_ext = 0;
            end
          end
          default: begin m_state = M_G; m_left = m_green[m_phase] * CD; m_ext = 0; end
        endcase
      end
      if (WEN && w_rise) m_walk = 1;
      if (r_rise) begin
        case (Time_Parameter_Selector)
          2'b00: m_green[Phase_Select] = (Time_Value == 0) ? 6 : int'(Time_Value);
          2'b01: m_yellow = (Time_Value == 0) ? 2 : int'(Time_Value);
          2'b10: m_extv   = (Time_Value == 0) ? 3 : int'(Time_Value);
          default: if (WEN) m_walkv = (Time_Value == 0) ? 3 : int'(Time_Value);
        endcase
      end
      sh2 = sh1; sh1 = Sensor;
      wh3 = wh2; wh2 = wh1; wh1 = Walk_Request;
      rh3 = rh2; rh2 = rh1; rh1 = Reprogram;
    end
  end

  logic [18:0] dut_vec, mdl_vec;
  logic [N-1:0] eg, ey;
  assign dut_vec = {Green, Yellow, Red, Walk, Phase, Remaining};
  always_comb begin
    eg = (m_state == M_G) ? N'(1 << m_phase) : '0;
    ey = (m_state == M_Y) ? N'(1 << m_phase) : '0;
    mdl_vec = {eg, ey, ~(eg | ey), (m_state == M_W), 2'(m_phase), TW'((m_left + CD - 1) / CD)};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        if (errors <= 20) $display("FAIL model_compare cyc=%0d got G/Y/R/W/P/Rem=%h expected=%h", cyc, dut_vec, mdl_vec);
      end
      checks++;
      if (!($countones(~Red) <= 1 && (Green & Yellow) == '0)) begin
        errors++;
        $display("FAIL one_non_red cyc=%0d got Red=%b Green=%b Yellow=%b expected at most one non-red", cyc, Red, Green, Yellow);
      end
    end
  end

  function automatic logic [8:0] lg(input int p);
    return {N'(1 << p), 4'b0, 1'b0};
  endfunction
  function automatic logic [8:0] ly(input int p);
    return {4'b0, N'(1 << p), 1'b0};
  endfunction

  // Waits (bounded) until the lamps equal tgt; n = negedges waited.
  task automatic wait_lamps(input logic [8:0] tgt, input int limit, output int n);
    n = 0;
    while ({Green, Yellow, Walk} !== tgt && n < limit) begin
      @(negedge clk); n++;
    end
  endtask

  // Counts cycles the current lamp pattern persists (bounded).
  task automatic dwell(output int n);
    logic [8:0] snap;
    snap = {Green, Yellow, Walk};
    n = 0;
    while ({Green, Yellow, Walk} === snap && n < 200) begin
      n++; @(negedge clk);
    end
  endtask

  task automatic pulse_reprogram(input logic [1:0] sel, input logic [1:0] ps, input logic [TW-1:0] val);
    Time_Parameter_Selector = sel; Phase_Select = ps; Time_Value = val;
    Reprogram = 1'b1;
    repeat (4) @(negedge clk);
    Reprogram = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if ({Green, Yellow, Red, Walk, Phase, Remaining} !== {4'h0, 4'h0, 4'hF, 1'b0, 2'd3, 4'd1}) begin
      errors++; $display("FAIL reset_state got %h expected %h", {Green, Yellow, Red, Walk, Phase, Remaining}, {4'h0, 4'h0, 4'hF, 1'b0, 2'd3, 4'd1});
    end
    Reset = 1'b0;
    dwell(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL first_allred_len got %0d expected 4", n); end
    checks++;
    if ({Green, Yellow, Walk} !== lg(0) || Remaining !== 4'd6) begin
      errors++; $display("FAIL first_green got lamps=%h rem=%0d expected lamps=%h rem=6", {Green, Yellow, Walk}, Remaining, lg(0));
    end
    dwell(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL green0_len got %0d expected 24", n); end
    dwell(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL yellow0_len got %0d expected 8", n); end
    dwell(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL allred0_len got %0d expected 4", n); end
    checks++;
    if ({Green, Yellow, Walk} !== lg(1) || Phase !== 2'd1) begin
      errors++; $display("FAIL phase1_green got lamps=%h phase=%0d expected lamps=%h phase=1", {Green, Yellow, Walk}, Phase, lg(1));
    end
    wait_lamps(lg(0), 400, n);
    checks++; if (n !== 108) begin errors++; $display("FAIL rotation_len got %0d expected 108", n); end
  endtask

  task automatic test_extension;
    int n;
    Sensor = 4'b0100;
    wait_lamps(lg(2), 400, n);
    checks++; if (n !== 72) begin errors++; $display("FAIL ext_reach_phase2 got %0d expected 72", n); end
    dwell(n);
    checks++; if (n !== 36) begin errors++; $display("FAIL ext_green_len got %0d expected 36", n); end
    checks++;
    if ({Green, Yellow, Walk} !== ly(2)) begin
      errors++; $display("FAIL ext_then_yellow got %h expected %h", {Green, Yellow, Walk}, ly(2));
    end
    Sensor = '0;
  endtask

  task automatic test_walk;
    int n, t0, t1;
    wait_lamps(lg(1), 400, n);
    checks++; if (n >= 400) begin errors++; $display("FAIL walk_wait_phase1 got timeout expected phase1 green"); end
    t0 = cyc;
    Walk_Request = 1'b1;
    repeat (4) @(negedge clk);
    Walk_Request = 1'b0;
`ifdef TRAFFIC_WALK_EN
    wait_lamps(9'b1, 400, n);
    checks++; if (cyc - t0 !== 108) begin errors++; $display("FAIL walk_start got %0d expected 108", cyc - t0); end
    checks++; if (Phase !== 2'd0) begin errors++; $display("FAIL walk_phase got %0d expected 0", Phase); end
    dwell(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL walk_len got %0d expected 12", n); end
`endif
    wait_lamps(lg(0), 400, n);
    checks++;
    if (cyc - t0 !== 108 + WALK_CYC) begin
      errors++; $display("FAIL walk_to_green0 got %0d expected %0d", cyc - t0, 108 + WALK_CYC);
    end
    t1 = cyc;
    wait_lamps(lg(1), 400, n);
    wait_lamps(lg(0), 400, n);
    checks++; if (cyc - t1 !== 144) begin errors++; $display("FAIL walk_latch_cleared got %0d expected 144", cyc - t1); end
  endtask

  task automatic test_reprogram;
    int n, t0;
    wait_lamps(lg(1), 400, n);
    t0 = cyc;
    pulse_reprogram(2'b00, 2'd1, 4'd9);
    dwell(n);
    checks++; if (cyc - t0 !== 24) begin errors++; $display("FAIL prog_current_green got %0d expected 24", cyc - t0); end
    wait_lamps(lg(1), 400, n);
    dwell(n);
    checks++; if (n !== 36) begin errors++; $display("FAIL prog_new_green got %0d expected 36", n); end
    pulse_reprogram(2'b00, 2'd1, 4'd0);
    wait_lamps(lg(1), 400, n);
    dwell(n);
    checks++; if (n !== 24) begin errors++; $display("FAIL prog_restore_default got %0d expected 24", n); end
  endtask

  task automatic test_reset_mid_yellow;
    int n, t0;
    wait_lamps(ly(3), 400, n);
    checks++; if (n >= 400) begin errors++; $display("FAIL midreset_wait got timeout expected yellow3"); end
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({Green, Yellow, Red, Walk, Phase, Remaining} !== {4'h0, 4'h0, 4'hF, 1'b0, 2'd3, 4'd1}) begin
      errors++; $display("FAIL midreset_state got %h expected %h", {Green, Yellow, Red, Walk, Phase, Remaining}, {4'h0, 4'h0, 4'hF, 1'b0, 2'd3, 4'd1});
    end
    Reset = 1'b0;
    t0 = cyc;
    wait_lamps(lg(0), 100, n);
    checks++; if (cyc - t0 !== 4) begin errors++; $display("FAIL midreset_green0 got %0d expected 4", cyc - t0); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      Reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 19) == 0) Sensor = N'($urandom);
      if ($urandom_range(0, 49) == 0) Walk_Request = ~Walk_Request;
      if ($urandom_range(0, 14) == 0) begin
        if (!Reprogram) begin
          Time_Parameter_Selector = 2'($urandom);
          Phase_Select = 2'($urandom);
          Time_Value = TW'($urandom);
        end
        Reprogram = ~Reprogram;
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_extension;
    test_walk;
    test_reprogram;
    test_reset_mid_yellow;
    test_random;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised multi-approach traffic signal controller. It generalises the single-intersection main/side controller to `NUM_PHASES` rotating green phases with:
- per-phase programmable green time,
- a one-shot sensor-driven green extension,
- an optional pedestrian walk interval.

It is a self-contained top-level block with an internal seconds-tick divider, input synchronisers, a timing register file and a phase FSM. It drives one green/yellow/red lamp triple per approach.

## Interface
Parameters:
- `NUM_PHASES`, 4: number of approaches; legal 2..8.
- `TIME_W`, 4: width of every time value, in seconds.
- `CLK_DIV`, 100000000: clk cycles per one-second tick; legal ≥ 2.
- `DEF_GREEN`, 6: reset green time, all phases.
- `DEF_YELLOW`, 2: reset yellow time.
- `DEF_EXT`, 3: reset extension time.
- `DEF_WALK`, 3: reset walk time.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Sensor` in NUM_PHASES: per-approach vehicle presence; asynchronous, 2-flop synchronised.
- `Walk_Request` in 1: pedestrian button; asynchronous, 2-flop synchronised.
- `Reprogram` in 1: asynchronous, 2-flop synchronised; its rising edge writes the timing register.
- `Time_Parameter_Selector` in 2: 00 green, 01 yellow, 10 extension, 11 walk.
- `Phase_Select` in $clog2(NUM_PHASES): green entry to write when selector = 00.
- `Time_Value` in TIME_W: value to write; 0 restores that entry's default.
- `Green`, `Yellow`, `Red` out NUM_PHASES each: lamp drives; one-hot per approach.
- `Walk` out 1: pedestrian walk lamp.
- `Phase` out $clog2(NUM_PHASES): currently served approach.
- `Remaining` out TIME_W: seconds left in the current state.

## Operation
- FSM states: GREEN → YELLOW → ALLRED → (WALK) → GREEN of the next phase.
- GREEN:
  - `Green[Phase]`=1; all other approaches are Red.
  - Load `green[Phase]` on entry.
- Extension:
  - Applies when `Remaining` would reach 0 in GREEN while synced `Sensor[Phase]`=1 and no extension has yet been taken this green.
  - Reload `ext` and set the extension flag.
  - At most one extension per green. The flag clears on GREEN entry.
- YELLOW: `Yellow[Phase]`=1; load `yellow` on entry.
- ALLRED:
  - All Red; fixed 1 tick.
  - On exit, `Phase` increments modulo NUM_PHASES.
  - Exit goes to WALK if the walk latch is set and the next phase is 0; otherwise to GREEN.
- WALK: all Red, `Walk`=1; load `walk` on entry. Walk latch clears on WALK entry.
- Walk latch:
  - Set by the rising edge of synced `Walk_Request`.
  - Held across any number of phases until served.
  - A request during WALK sets the latch again for the next cycle of phases.
- Programming:
  - On a synced `Reprogram` rising edge, write the selected entry.
  - The new value takes effect at the next load of that entry, never mid-state.
  - `Phase_Select` ≥ NUM_PHASES: write ignored.
- Invariant: at most one approach is non-Red at any time. Green and Yellow are never both active on the same approach.

## Timing
- Reset (while `Reset`=1, registered):
  - state = ALLRED; `Phase`=NUM_PHASES-1; `Remaining`=1.
  - `Red`=all ones; `Green`=`Yellow`=0; `Walk`=0.
  - Walk latch, extension flag and synchronisers cleared.
  - Divider = 0; all timing entries = defaults.
- After reset: the first GREEN is phase 0, entered 1 tick after reset release.
- Tick:
  - Divider counts 0..CLK_DIV-1 and pulses a tick when wrapping.
  - The divider is cleared on every state entry and every extension reload, so each state lasts exactly N×CLK_DIV cycles.
- `Remaining`:
  - Decrements on each tick.
  - A tick with `Remaining`=1 causes the transition (or the extension reload).
  - New state outputs and the new `Remaining` appear on the following clk edge.
- Input latency: asynchronous input to synced value is 2 cycles; an edge is detected on the 3rd cycle.
- A sensor edge landing on the expiry tick counts only if synced `Sensor` is 1 in that same cycle.
- Reset mid-state: abandons the state immediately, with no yellow; pending walk and programmed values are lost.
- Simultaneous Reprogram and load of the same entry: the state loads the old value; the write lands on the same edge.

## Configuration
- `TRAFFIC_WALK_EN` defined:
  - Walk latch and WALK state are present.
  - `Time_Parameter_Selector`=11 writes `walk`.
- `TRAFFIC_WALK_EN` undefined:
  - No walk latch or WALK state; ALLRED always goes to GREEN.
  - `Walk` is tied to 0 and `Walk_Request` is ignored.
  - Selector 11 writes are ignored.

## Test plan
All scenarios use CLK_DIV=4, NUM_PHASES=4, defaults, and no sensors or walk unless stated.
- Reset release, no inputs:
  - ALLRED 4 cycles.
  - Phase 0 green 24 cycles, yellow 8, allred 4.
  - Then phase 1 green; rotation continues 0→1→2→3→0.
- `Sensor[2]` held high:
  - Phase 2 green lasts 6+3=9 s (36 cycles), then yellow.
  - Exactly one extension is taken.
- Walk request pulse during phase 1 green:
  - After phase 3 ALLRED, WALK with `Walk`=1 for 12 cycles.
  - Then phase 0 green; latch cleared.
- Reprogram selector=00, `Phase_Select`=1, value 9 during phase 1 green:
  - Current green is unchanged.
  - Next phase-1 green is 36 cycles.
  - Rewriting value 0 restores 24 cycles.
- Reset asserted mid-yellow of phase 3: next cycle all Red and `Remaining`=1; after release, phase 0 green.
- Continuous assertion check: never two approaches non-Red simultaneously.
